ro_lock_ctrl: RTL



---
 rtl/ro_lock_ctrl.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/ro_lock_ctrl.sv
// Ring-oscillator lock sequencer: SAR search of freq_sel against a reference window,
// then bang-bang tracking from the phase detector.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | disabled or not yet started, ring off
// S_SET     | set the trial bit of freq_sel_o
// S_SETTLE  | wait SETTLE_CYC cycles for the ring to settle
// S_MEASURE | count gen edges over the latched number of ref edges
// S_DECIDE  | keep or clear the trial bit, advance to the next bit
// S_CHECK   | final tolerance check of the searched word
// S_TRACK   | bang-bang tracking from pd_i, locked_o high
// S_FAIL    | search missed tolerance, word held, fail_o high
`timescale 1ns/1ps
module ro_lock_ctrl #(
  parameter int CTRL_WIDTH = 5,
  parameter int WIN_WIDTH  = 10,
  parameter int SETTLE_CYC = 64,
  parameter int LOCK_TOL   = 2,
  parameter int PD_WIDTH   = 4
) (
  input  logic                  fpga_clk_i,
  input  logic                  rst_n_i,
  input  logic                  enable_i,
  input  logic                  start_i,
  input  logic [WIN_WIDTH-1:0]  win_len_i,
  input  logic                  ref_i,
  input  logic                  gen_i,
  input  logic                  pd_i,
  output logic [CTRL_WIDTH-1:0] freq_sel_o,
  output logic                  ro_enable_o,
  output logic                  busy_o,
  output logic                  locked_o,
  output logic                  fail_o
);

  localparam int GW = WIN_WIDTH + 2;
  localparam int SW = $clog2(SETTLE_CYC + 1);
  localparam int BW = (CTRL_WIDTH > 1) ? $clog2(CTRL_WIDTH) : 1;
  localparam int HW = PD_WIDTH + 1;
  localparam int NS = 1 << PD_WIDTH;
  localparam logic [HW-1:0] UP_TH = HW'((3 * NS + 3) / 4);
  localparam logic [HW-1:0] DN_TH = HW'(NS / 4);
  localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SET, S_SETTLE, S_MEASURE, S_DECIDE, S_CHECK, S_TRACK, S_FAIL
  } state_t;

  state_t               state;
  logic [2:0]           ref_sync, gen_sync;
  logic [1:0]           pd_sync;
  logic [BW-1:0]        bit_idx;
  logic [SW-1:0]        settle_cnt;
  logic [WIN_WIDTH-1:0] win_q, ref_cnt;
  logic [GW-1:0]        gen_cnt;
  logic [HW-1:0]        hit_cnt;
  logic [PD_WIDTH-1:0]  sample_cnt;
  logic                 final_q, trk_wait;

  logic                 ref_rise, gen_rise, ref_done, within_tol;
  logic [GW-1:0]        win_ext, gen_next, abs_diff;
  logic [HW-1:0]        hit_next;

  // ref and gen see identical synchronizer depth, so counts carry no latency bias
  always_ff @(posedge fpga_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ref_sync <= '0;
      gen_sync <= '0;
      pd_sync  <= '0;
    end else begin
      ref_sync <= {ref_sync[1:0], ref_i};
      gen_sync <= {gen_sync[1:0], gen_i};
      pd_sync  <= {pd_sync[0], pd_i};
    end
  end

  assign ref_rise   = ref_sync[1] & ~ref_sync[2];
  assign gen_rise   = gen_sync[1] & ~gen_sync[2];
  assign win_ext    = GW'(win_q);
  assign gen_next   = (gen_rise && gen_cnt != '1) ? gen_cnt + GW'(1) : gen_cnt;
  assign ref_done   = ref_rise && (ref_cnt == win_q - WIN_WIDTH'(1));
  assign abs_diff   = (gen_cnt > win_ext) ? gen_cnt - win_ext : win_ext - gen_cnt;
  assign within_tol = abs_diff <= GW'(LOCK_TOL);
  assign hit_next   = hit_cnt + HW'(pd_sync[1]);

  always_ff @(posedge fpga_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state       <= S_IDLE;
      freq_sel_o  <= '0;
      ro_enable_o <= 1'b0;
      busy_o      <= 1'b0;
      locked_o    <= 1'b0;
      fail_o      <= 1'b0;
      bit_idx     <= '0;
      settle_cnt  <= '0;
      win_q       <= '0;
      ref_cnt     <= '0;
      gen_cnt     <= '0;
      hit_cnt     <= '0;
      sample_cnt  <= '0;
      final_q     <= 1'b0;
      trk_wait    <= 1'b0;
    end else if (!enable_i) begin
      state       <= S_IDLE;
      ro_enable_o <= 1'b0;
      busy_o      <= 1'b0;
      locked_o    <= 1'b0;
      fail_o      <= 1'b0;
    end else if (start_i && (state == S_IDLE || state == S_TRACK || state == S_FAIL)) begin
      state       <= S_SET;
      freq_sel_o  <= '0;
      ro_enable_o <= 1'b1;
      busy_o      <= 1'b1;
      locked_o    <= 1'b0;
      fail_o      <= 1'b0;
      bit_idx     <= BW'(CTRL_WIDTH - 1);
      win_q       <= (win_len_i == '0) ? WIN_WIDTH'(1) : win_len_i;
      final_q     <= 1'b0;
    end else begin
      case (state)
        S_SET: begin
          freq_sel_o[bit_idx] <= 1'b1;
          settle_cnt          <= SETTLE_LOAD;
          state               <= S_SETTLE;
        end
        S_SETTLE: begin
          if (settle_cnt == '0) begin
            ref_cnt <= '0;
            gen_cnt <= '0;
            state   <= S_MEASURE;
          end else begin
            settle_cnt <= settle_cnt - SW'(1);
          end
        end
        S_MEASURE: begin
          gen_cnt <= gen_next;
          if (ref_rise) ref_cnt <= ref_cnt + WIN_WIDTH'(1);
          if (ref_done) state <= final_q ? S_CHECK : S_DECIDE;
        end
        S_DECIDE: begin
          if (gen_cnt > win_ext) freq_sel_o[bit_idx] <= 1'b0;
          settle_cnt <= SETTLE_LOAD;
          if (bit_idx == '0) begin
            final_q <= 1'b1;
            state   <= S_SETTLE;
          end else begin
            bit_idx <= bit_idx - BW'(1);
            state   <= S_SET;
          end
        end
        S_CHECK: begin
          busy_o     <= 1'b0;
          hit_cnt    <= '0;
          sample_cnt <= '0;
          trk_wait   <= 1'b0;
          if (within_tol) begin
            locked_o <= 1'b1;
            state    <= S_TRACK;
          end else begin
            fail_o <= 1'b1;
            state  <= S_FAIL;
          end
        end
        S_TRACK: begin
          if (trk_wait) begin
            if (settle_cnt == '0) trk_wait <= 1'b0;
            else                  settle_cnt <= settle_cnt - SW'(1);
          end else if (ref_rise) begin
            sample_cnt <= sample_cnt + PD_WIDTH'(1);
            hit_cnt    <= hit_next;
            if (sample_cnt == '1) begin
              hit_cnt <= '0;
              // a step only happens when the word actually moves; saturation keeps sampling
              if (hit_next >= UP_TH && freq_sel_o != '1) begin
                freq_sel_o <= freq_sel_o + CTRL_WIDTH'(1);
                trk_wait   <= 1'b1;
                settle_cnt <= SETTLE_LOAD;
              end else if (hit_next <= DN_TH && freq_sel_o != '0) begin
                freq_sel_o <= freq_sel_o - CTRL_WIDTH'(1);
                trk_wait   <= 1'b1;
                settle_cnt <= SETTLE_LOAD;
              end
            end
          end
        end
        S_IDLE, S_FAIL: ;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
